// File: rtl/wb_lsu_master.sv
// Wishbone pipelined-mode bus master for single CPU load/store requests.
// One request becomes at most one single-beat Wishbone cycle. The block
// generates byte-lane selects, replicates store data across lanes, aligns
// and extends load data, and flags misaligned, reserved-size or timed-out
// accesses.
module wb_lsu_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    output logic [3:0]            o_wb_sel,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [31:0]           i_wb_data
);

    // One spare bit so the counter can always hold TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_ACK,
        S_FIN
    } state_t;

    state_t                  state_q;

    // Latched request fields
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [1:0]              size_q;
    logic                    unsg_q;
    logic [CNT_W-1:0]        cnt_q;

    // Output registers
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic                    wb_we_q;
    logic [ADDR_WIDTH-1:0]   wb_addr_q;
    logic [31:0]             wb_data_q;
    logic [3:0]              wb_sel_q;

    // Next-value helpers derived from the latched request
    logic                    bad_d;
    logic [3:0]              sel_d;
    logic [31:0]             wb_data_d;
    logic [31:0]             shifted_d;
    logic [31:0]             rdata_d;

    // Classify the latched request: illegal alignment/size and lane select.
    always_comb begin
        bad_d = 1'b0;
        sel_d = 4'b1111;
        case (size_q)
            SIZE_BYTE: begin
                bad_d = 1'b0;
                sel_d = 4'b0001 << addr_q[1:0];
            end
            SIZE_HALF: begin
                bad_d = addr_q[0];
                sel_d = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                bad_d = |addr_q[1:0];
                sel_d = 4'b1111;
            end
            default: begin
                bad_d = 1'b1;
                sel_d = 4'b1111;
            end
        endcase
    end

    // Store data replicated so each enabled lane carries the right byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wb_data_d[gi*8 +: 8] =
            (size_q == SIZE_WORD) ? wdata_q[gi*8 +: 8] :
            (size_q == SIZE_HALF) ? wdata_q[(gi % 2)*8 +: 8] :
                                    wdata_q[7:0];
    end

    // Move the addressed lane down to bit 0, then sign or zero extend.
    always_comb begin
        shifted_d = i_wb_data >> {addr_q[1:0], 3'b000};
        rdata_d   = i_wb_data;
        case (size_q)
            SIZE_BYTE: rdata_d = unsg_q ? {24'h000000, shifted_d[7:0]}
                                        : {{24{shifted_d[7]}}, shifted_d[7:0]};
            SIZE_HALF: rdata_d = unsg_q ? {16'h0000, shifted_d[15:0]}
                                        : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default:   rdata_d = i_wb_data;
        endcase
    end

    // Request sequencing, bus handshake, timeout and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            unsg_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        addr_q  <= i_addr[ADDR_WIDTH-1:0];
                        wdata_q <= i_wdata;
                        size_q  <= i_size;
                        unsg_q  <= i_unsigned;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_d) begin
                        // Illegal request never reaches the bus.
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_FIN;
                    end else begin
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        wb_we_q   <= we_q;
                        wb_addr_q <= {addr_q[ADDR_WIDTH-1:2], 2'b00};
                        wb_data_q <= wb_data_d;
                        wb_sel_q  <= sel_d;
                        cnt_q     <= '0;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cnt_q == TIMEOUT_CNT) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!i_wb_stall) begin
                            // Beat accepted: strobe only ever covers one beat.
                            stb_q <= 1'b0;
                            if (i_wb_ack) begin
                                cyc_q   <= 1'b0;
                                done_q  <= 1'b1;
                                if (!we_q) begin
                                    rdata_q <= rdata_d;
                                end
                                state_q <= S_FIN;
                            end else begin
                                state_q <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (cnt_q == TIMEOUT_CNT) begin
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_FIN;
                    end else if (i_wb_ack) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = wb_we_q;
    assign o_wb_addr = wb_addr_q;
    assign o_wb_data = wb_data_q;
    assign o_wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a scoreboarded Wishbone slave model.
module tb_wb_lsu_master;

    localparam int AW = 10;

    logic          clk;
    logic          i_rst;
    logic          i_req;
    logic          i_we;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic [1:0]    i_size;
    logic          i_unsigned;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [31:0]   o_rdata;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic [31:0]   i_wb_data;

    wb_lsu_master #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rdata    (o_rdata),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .i_wb_data  (i_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [31:0]   rdata;
    } res_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    sel;
        logic [31:0]   data;
        logic          chk_data;
    } bus_t;

    res_t exp_res[$];
    bus_t exp_bus[$];

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration, set by the stimulus before each request
    int          stall_left = 0;
    int          ack_delay  = 0;
    bit          no_ack     = 0;
    logic [31:0] slave_rdata = '0;
    int          wait_left  = 0;
    int          beats      = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model: stalls, accepts, acks, and checks every strobed beat.
    always @(posedge clk) begin
        #1;
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_data  = 32'h5A5A_A5A5;
        if (i_rst || !o_wb_cyc) begin
            wait_left = 0;
        end else if (o_wb_stb) begin
            if (exp_bus.size() == 0) begin
                check32("unexpected_stb", 32'(o_wb_stb), 32'd0);
            end else begin
                check32("bus_we",   32'(o_wb_we),   32'(exp_bus[0].we));
                check32("bus_addr", 32'(o_wb_addr), 32'(exp_bus[0].addr));
                check32("bus_sel",  32'(o_wb_sel),  32'(exp_bus[0].sel));
                if (exp_bus[0].chk_data) begin
                    check32("bus_data", o_wb_data, exp_bus[0].data);
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    void'(exp_bus.pop_front());
                    beats++;
                    if (!no_ack) begin
                        if (ack_delay == 0) begin
                            i_wb_ack  = 1'b1;
                            i_wb_data = slave_rdata;
                        end else begin
                            wait_left = ack_delay;
                        end
                    end
                end
            end
        end else if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) begin
                i_wb_ack  = 1'b1;
                i_wb_data = slave_rdata;
            end
        end
    end

    // Completion monitor: every o_done pulse must match a queued result.
    always @(posedge clk) begin
        #1;
        if (o_done) begin
            if (exp_res.size() == 0) begin
                check32("unexpected_done", 32'(o_done), 32'd0);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check32("done_err", 32'(o_err), 32'(r.err));
                check32("done_rdata", o_rdata, r.rdata);
            end
        end
    end

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           input int stall, input int ackd, input bit noack,
                           input logic [31:0] sdata, input bit bus, input logic [3:0] sel,
                           input logic [31:0] bus_data, input logic exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat);
        bus_t b;
        res_t r;
        int   n;
        int   beats0;
        bit   seen;
        stall_left  = stall;
        ack_delay   = ackd;
        no_ack      = noack;
        slave_rdata = sdata;
        if (bus) begin
            b.we       = we;
            b.addr     = {addr[AW-1:2], 2'b00};
            b.sel      = sel;
            b.data     = bus_data;
            b.chk_data = we;
            exp_bus.push_back(b);
        end
        r.err   = exp_err;
        r.rdata = exp_rdata;
        exp_res.push_back(r);
        beats0 = beats;
        i_we       = we;
        i_addr     = addr;
        i_wdata    = wdata;
        i_size     = size;
        i_unsigned = uns;
        i_req      = 1'b1;
        n    = 0;
        seen = 0;
        while (n < 64 && !seen) begin
            @(posedge clk);
            #3;
            n++;
            if (n == 1) begin
                i_req = 1'b0;
                check32({tag, "_busy"}, 32'(o_busy), 32'd1);
            end
            if (o_done) seen = 1;
        end
        check32({tag, "_latency"}, n, exp_lat);
        check32({tag, "_beats"}, beats - beats0, bus ? 1 : 0);
        @(posedge clk);
        #3;
        check32({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check32({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        $display("txn %s: we=%0d addr=%h size=%0d latency=%0d err=%0d rdata=%h",
                 tag, we, addr, size, n, o_err, o_rdata);
    endtask

    initial begin
        bus_t b;
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        i_size = '0; i_unsigned = 1'b0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
        repeat (3) @(posedge clk);
        #3;
        check32("rst_cyc",   32'(o_wb_cyc),  32'd0);
        check32("rst_stb",   32'(o_wb_stb),  32'd0);
        check32("rst_we",    32'(o_wb_we),   32'd0);
        check32("rst_sel",   32'(o_wb_sel),  32'd0);
        check32("rst_addr",  32'(o_wb_addr), 32'd0);
        check32("rst_data",  o_wb_data,      32'd0);
        check32("rst_busy",  32'(o_busy),    32'd0);
        check32("rst_done",  32'(o_done),    32'd0);
        check32("rst_err",   32'(o_err),     32'd0);
        check32("rst_rdata", o_rdata,        32'd0);
        $display("txn reset: outputs checked");
        i_rst = 1'b0;
        @(posedge clk);
        #3;

        //       tag     we  addr          wdata         sz     u  st ad na sdata          bus sel      busdata       err   rdata         lat
        run_req("lw",    0, 32'h004,      32'h0,        2'b10, 0, 0, 0, 0, 32'h00C00193, 1, 4'b1111, 32'h0,        1'b0, 32'h00C00193, 3);
        run_req("lb",    0, 32'h00B,      32'h0,        2'b00, 0, 0, 0, 0, 32'hFF718393, 1, 4'b1000, 32'h0,        1'b0, 32'hFFFFFFFF, 3);
        run_req("lbu",   0, 32'h00B,      32'h0,        2'b00, 1, 0, 0, 0, 32'hFF718393, 1, 4'b1000, 32'h0,        1'b0, 32'h000000FF, 3);
        run_req("sh",    1, 32'h012,      32'h1234BEEF, 2'b01, 0, 0, 0, 0, 32'h0,        1, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h000000FF, 3);
        run_req("sw_mis",1, 32'h006,      32'h11223344, 2'b10, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h00000000, 2);
        run_req("lh_mis",0, 32'h003,      32'h0,        2'b01, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h00000000, 2);
        run_req("rsvd",  0, 32'h000,      32'h0,        2'b11, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h00000000, 2);
        run_req("stall", 0, 32'h020,      32'h0,        2'b10, 0, 3, 0, 0, 32'h12345678, 1, 4'b1111, 32'h0,        1'b0, 32'h12345678, 6);
        run_req("lh_wait",0,32'h02E,      32'h0,        2'b01, 0, 0, 2, 0, 32'h80010000, 1, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 5);
        run_req("sb",    1, 32'h001,      32'h123456A5, 2'b00, 0, 0, 0, 0, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'hFFFF8001, 3);
        run_req("tmo",   0, 32'h040,      32'h0,        2'b10, 0, 0, 0, 1, 32'h0,        1, 4'b1111, 32'h0,        1'b1, 32'h00000000, 11);

        // Reset while waiting for ack: bus released, no completion.
        stall_left = 0; ack_delay = 5; no_ack = 0; slave_rdata = 32'h0BAD0BAD;
        b.we = 1'b0; b.addr = 10'h050; b.sel = 4'b1111; b.data = '0; b.chk_data = 1'b0;
        exp_bus.push_back(b);
        i_we = 1'b0; i_addr = 32'h050; i_size = 2'b10; i_unsigned = 1'b0; i_req = 1'b1;
        @(posedge clk); #3; i_req = 1'b0;
        @(posedge clk); #3;
        @(posedge clk); #3;
        check32("ack_state_cyc", 32'(o_wb_cyc), 32'd1);
        check32("ack_state_stb", 32'(o_wb_stb), 32'd0);
        i_rst = 1'b1;
        @(posedge clk); #3;
        i_rst = 1'b0;
        check32("midrst_cyc",  32'(o_wb_cyc), 32'd0);
        check32("midrst_stb",  32'(o_wb_stb), 32'd0);
        check32("midrst_busy", 32'(o_busy),   32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #3;
            check32("midrst_no_done", 32'(o_done), 32'd0);
        end
        $display("txn midrst: reset in ACK, bus released");

        run_req("lw_hi", 0, 32'hFFFFF3FC, 32'h0,        2'b10, 0, 0, 0, 0, 32'hCAFEF00D, 1, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D, 3);

        check32("res_queue_empty", exp_res.size(), 0);
        check32("bus_queue_empty", exp_bus.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
